// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  // Width of one instruction word handed to decode.
  localparam int ISA_WIDTH = 32;

  // Default address width and reset PC of the fetch unit.
  localparam int          ADDR_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;

  // Fetch FSM encoding.
  localparam int IFU_STATE_WIDTH = 2;

  typedef enum logic [IFU_STATE_WIDTH-1:0] {
    IFU_REQ  = 2'd0,  // presenting a request to instruction memory
    IFU_WAIT = 2'd1,  // one request outstanding, waiting for its response
    IFU_HOLD = 2'd2,  // fetched word presented to decode
    IFU_HALT = 2'd3   // stopped until reset
  } ifu_state_t;

  // True when the state is one in which a memory response is expected.
  function automatic logic state_expects_resp(input ifu_state_t st);
    return (st == IFU_WAIT);
  endfunction

endpackage

// File: rtl/ifu_reg.sv
// Parameterised register with synchronous active-high reset and write enable.
module ifu_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: reset value on rst, otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time to
// instruction memory and hands the fetched word with its PC to decode.
module ifu
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [ISA_WIDTH-1:0]  imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ISA_WIDTH-1:0]  inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  ifu_state_t            state_r;
  ifu_state_t            state_next_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_d_s;
  logic                  pc_en_s;
  logic                  capture_en_s;
  logic                  discard_r;
  logic                  discard_d_s;
  logic                  discard_en_s;
  logic [ADDR_WIDTH-1:0] redirect_target_s;
  logic [ADDR_WIDTH-1:0] pc_plus4_s;
  logic                  resp_expected_s;

  // Redirect targets are word aligned; PC increment wraps naturally.
  assign redirect_target_s = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign pc_plus4_s        = pc_r + PC_STEP;
  assign resp_expected_s   = state_expects_resp(state_r);

  // Outputs are decoded from registered state; request is masked during reset.
  assign imem_req_valid = (state_r == IFU_REQ) && !rst;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = (state_r == IFU_HOLD);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IFU_REQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and register-enable logic: halt beats redirect beats normal flow.
  always_comb begin
    state_next_s = state_r;
    pc_d_s       = pc_r;
    pc_en_s      = 1'b0;
    capture_en_s = 1'b0;
    discard_d_s  = discard_r;
    discard_en_s = 1'b0;
    case (state_r)
      IFU_REQ: begin
        if (halt) begin
          state_next_s = IFU_HALT;
        end else if (redirect_valid) begin
          pc_d_s       = redirect_target_s;
          pc_en_s      = 1'b1;
          state_next_s = IFU_REQ;
        end else if (imem_req_ready) begin
          state_next_s = IFU_WAIT;
        end else begin
          state_next_s = IFU_REQ;
        end
      end
      IFU_WAIT: begin
        if (halt) begin
          state_next_s = IFU_HALT;
        end else if (redirect_valid) begin
          pc_d_s       = redirect_target_s;
          pc_en_s      = 1'b1;
          discard_en_s = 1'b1;
          if (imem_resp_valid) begin
            // The in-flight word belongs to the old path: drop it now.
            discard_d_s  = 1'b0;
            state_next_s = IFU_REQ;
          end else begin
            // Response still to come; remember to throw it away.
            discard_d_s  = 1'b1;
            state_next_s = IFU_WAIT;
          end
        end else if (imem_resp_valid && resp_expected_s) begin
          if (discard_r) begin
            discard_d_s  = 1'b0;
            discard_en_s = 1'b1;
            state_next_s = IFU_REQ;
          end else begin
            capture_en_s = 1'b1;
            state_next_s = IFU_HOLD;
          end
        end else begin
          state_next_s = IFU_WAIT;
        end
      end
      IFU_HOLD: begin
        if (halt) begin
          state_next_s = IFU_HALT;
        end else if (redirect_valid) begin
          // A same-cycle handshake is still consumed; only the PC differs.
          pc_d_s       = redirect_target_s;
          pc_en_s      = 1'b1;
          state_next_s = IFU_REQ;
        end else if (inst_ready) begin
          pc_d_s       = pc_plus4_s;
          pc_en_s      = 1'b1;
          state_next_s = IFU_REQ;
        end else begin
          state_next_s = IFU_HOLD;
        end
      end
      IFU_HALT: begin
        state_next_s = IFU_HALT;
      end
      default: begin
        state_next_s = IFU_HALT;
      end
    endcase
  end

  ifu_reg #(.WIDTH(ADDR_WIDTH), .RESET_VALUE(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en_s),
    .d   (pc_d_s),
    .q   (pc_r)
  );

  ifu_reg #(.WIDTH(ISA_WIDTH), .RESET_VALUE({ISA_WIDTH{1'b0}})) u_inst_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture_en_s),
    .d   (imem_resp_data),
    .q   (inst)
  );

  ifu_reg #(.WIDTH(ADDR_WIDTH), .RESET_VALUE({ADDR_WIDTH{1'b0}})) u_inst_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture_en_s),
    .d   (pc_r),
    .q   (inst_pc)
  );

  ifu_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u_discard_reg (
    .clk (clk),
    .rst (rst),
    .en  (discard_en_s),
    .d   (discard_d_s),
    .q   (discard_r)
  );

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch unit.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;

  always #5 clk = ~clk;

  ifu #(.ADDR_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: PC, whether a fetch is in flight (and stale), whether a word is held.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_inst = 32'd0;
  logic [31:0] m_ipc = 32'd0;
  bit          m_pending = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_have = 1'b0;
  bit          m_halted = 1'b0;
  bit          checking = 1'b0;

  // Memory model: countdown to the single outstanding response.
  int          mem_cnt = 0;
  int          fixed_delay = 1;
  bit          rand_delay = 1'b0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every cycle against the model, mid-cycle.
  always @(negedge clk) begin
    if (checking) begin
      chk("req_valid",  {31'd0, imem_req_valid},
          {31'd0, (!rst && !m_halted && !m_pending && !m_have)});
      chk("req_addr",   imem_req_addr, m_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_have && !m_halted)});
      chk("inst",       inst, m_inst);
      chk("inst_pc",    inst_pc, m_ipc);
    end
  end

  // One clock: sample inputs mid-cycle, advance model and memory after the edge.
  task automatic tick();
    bit          s_rst, s_rdy, s_rv, s_ir, s_redv, s_hlt, s_acc;
    logic [31:0] s_rd, s_rpc;
    @(negedge clk);
    s_rst  = rst;
    s_rdy  = imem_req_ready;
    s_rv   = imem_resp_valid;
    s_rd   = imem_resp_data;
    s_ir   = inst_ready;
    s_redv = redirect_valid;
    s_rpc  = redirect_pc;
    s_hlt  = halt;
    s_acc  = imem_req_valid && imem_req_ready;
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_pc = RPC; m_inst = 32'd0; m_ipc = 32'd0;
      m_pending = 1'b0; m_stale = 1'b0; m_have = 1'b0; m_halted = 1'b0;
      checking = 1'b1;
    end else if (!m_halted) begin
      if (s_hlt) begin
        m_halted = 1'b1;
      end else if (s_redv) begin
        m_pc   = s_rpc & 32'hFFFF_FFFC;
        m_have = 1'b0;
        if (m_pending) begin
          if (s_rv) begin
            m_pending = 1'b0;
            m_stale   = 1'b0;
          end else begin
            m_stale = 1'b1;
          end
        end
      end else if (m_pending) begin
        if (s_rv) begin
          m_pending = 1'b0;
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            m_have = 1'b1;
            m_inst = s_rd;
            m_ipc  = m_pc;
          end
        end
      end else if (m_have) begin
        if (s_ir) begin
          m_have = 1'b0;
          m_pc   = m_pc + 32'd4;
        end
      end else if (s_rdy) begin
        m_pending = 1'b1;
      end
    end
    if (s_rst) mem_cnt = 0;
    else if (s_acc) mem_cnt = rand_delay ? int'($urandom_range(3, 1)) : fixed_delay;
    else if (mem_cnt > 0) mem_cnt--;
    imem_resp_valid = (mem_cnt == 1);
    if (mem_cnt == 1) begin
      imem_resp_data = $urandom;
      last_data      = imem_resp_data;
    end
  endtask

  // Advance until decode sees a valid word, within a cycle budget.
  task automatic wait_inst(input int budget);
    int n = 0;
    #1;
    while (!inst_valid && n < budget) begin
      tick();
      #1;
      n++;
    end
    n_checks++;
    if (!inst_valid) begin
      n_fail++;
      $display("FAIL wait_inst: inst_valid still 0 after %0d cycles", budget);
    end
  endtask

  initial begin
    // Reset, always-ready memory, 1-cycle responses, decode always ready.
    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("p1_req0_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("p1_req0_addr", imem_req_addr, 32'h8000_0000);
    chk("p1_c1_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("p1_c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("p1_c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("p1_c3_inst_pc", inst_pc, 32'h8000_0000);
    tick();
    chk("p1_req1_addr", imem_req_addr, 32'h8000_0004);
    tick(); tick(); tick();
    chk("p1_req2_addr", imem_req_addr, 32'h8000_0008);

    // Decode stalls in HOLD for 5 cycles.
    rst = 1'b1; inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    wait_inst(10);
    chk("p2_inst_pc", inst_pc, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p2_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("p2_hold_noreq", {31'd0, imem_req_valid}, 32'd0);
      chk("p2_hold_pc", inst_pc, 32'h8000_0000);
      chk("p2_hold_inst", inst, last_data);
    end
    inst_ready = 1'b1; fixed_delay = 2;
    tick();
    inst_ready = 1'b0;
    chk("p2_next_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("p2_next_addr", imem_req_addr, 32'h8000_0004);

    // Redirect while waiting; the late response must be dropped.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("p3_drop_resp_seen", {31'd0, imem_resp_valid}, 32'd1);
    tick();
    chk("p3_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("p3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("p3_req_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coincident with the HOLD handshake.
    fixed_delay = 1;
    wait_inst(10);
    chk("p4_inst_pc", inst_pc, 32'h8000_0100);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("p4_consumed", {31'd0, inst_valid}, 32'd0);
    chk("p4_req_addr", imem_req_addr, 32'h8000_1000);

    // Halt in HOLD, then reset restarts fetch.
    wait_inst(10);
    halt = 1'b1;
    tick();
    halt = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("p5_halt_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("p5_halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_ready = 1'b0; #1;
    chk("p5_restart_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("p5_restart_addr", imem_req_addr, RPC);

    // PC wrap-around via redirect to the top word.
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("p6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    wait_inst(10);
    chk("p6_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("p6_wrap_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("p6_wrap_addr", imem_req_addr, 32'h0000_0000);

    // Randomized traffic.
    rand_delay = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(99, 0) < 2);
      imem_req_ready = ($urandom_range(99, 0) < 70);
      inst_ready     = ($urandom_range(99, 0) < 60);
      redirect_valid = ($urandom_range(99, 0) < 5);
      halt           = ($urandom_range(299, 0) == 0);
      if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_pc = $urandom;
      // A request is never offered to memory in a cycle it gets redirected.
      if (redirect_valid) imem_req_ready = 1'b0;
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
